idmem_port: RTL and testbench
=============================

# idmem_port

Initiator-side access controller for the combined 64-word instruction/data memory of the multicycle processor. Accepts instruction-fetch and load/store requests from the control path and converts byte addresses to word indices. Drives the memory's address, write-data and write-enable lines, then captures read data into an instruction register (IR) or memory data register (MDR). Sits between the multicycle control FSM/datapath and the memory, and serialises all memory traffic through one port.

## Interface
- `ADDR_W`, default 5: memory depth exponent; memory holds 2·2^ADDR_W words (64 by default).
- `DATA_W`, default 32: word width.
- `WAIT_CYCLES`, default 0: extra access cycles inserted before completion (0–15).
- Clock and reset: one clock; reset is synchronous and active-high.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `if_req` in 1: instruction-fetch request (level).
- `if_pc` in DATA_W: fetch byte address.
- `ls_req` in 1: load/store request (level).
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_addr` in DATA_W: load/store byte address.
- `ls_wd` in DATA_W: store data.
- `ack` out 1: one-cycle completion pulse.
- `busy` out 1: high whenever the state is not IDLE.
- `fault` out 1: the completed transaction faulted; valid with `ack` and held until the next transaction starts.
- `ir` out DATA_W: last fetched instruction.
- `mdr` out DATA_W: last loaded data word.
- `mem_we` out 1: memory write enable.
- `mem_addr` out DATA_W: word index to memory, zero-extended.
- `mem_wd` out DATA_W: memory write data.
- `mem_rd` in DATA_W: asynchronous memory read data.

## Operation
- **States:** IDLE, ACCESS, DONE.
- **IDLE:**
  - Requests are sampled only in IDLE.
  - `ls_req` has priority over `if_req` when both are high; the losing request is not queued.
  - On acceptance, latch the operation (FETCH/LOAD/STORE), the address and `ls_wd`.
  - Load the wait counter with WAIT_CYCLES, clear `fault`, and go to ACCESS.
- **Range check at acceptance:**
  - A byte address ≥ 4·2·2^ADDR_W (256 by default) is out of range.
  - An out-of-range request sets `fault` and goes directly to DONE; no memory access occurs.
- **ACCESS:**
  - `mem_addr` = latched address bits [ADDR_W+2:2], zero-extended to DATA_W.
  - `mem_wd` = latched store data.
  - The counter decrements each cycle.
  - When the counter is 0:
    - FETCH captures `mem_rd` into `ir`.
    - LOAD captures `mem_rd` into `mdr`.
    - STORE asserts `mem_we` for exactly this one cycle.
    - The state then goes to DONE.
- **DONE:** `ack` = 1 for one cycle, then return to IDLE. Requests present in DONE are ignored.
- **Request hold rule:** the requester holds its request until it sees `ack` and must deassert it the cycle after. A request still high in IDLE is treated as a new transaction.
- **Register hold:** `ir` and `mdr` change only on a successful capture. A faulted transaction leaves both unchanged.
- **Write-enable decode:** `mem_we` is combinational: (state==ACCESS) & (cnt==0) & (op==STORE) & !RST.

## Timing
- **Reset:**
  - State goes to IDLE.
  - `ack`, `busy`, `fault`, `mem_we` = 0.
  - `ir`, `mdr`, `mem_addr`, `mem_wd` = 0.
  - Counter = 0.
- **Latency:** a request accepted in IDLE at edge N produces `ack` high in cycle N+2+WAIT_CYCLES. A faulted request produces `ack` in cycle N+1.
- **Throughput:** back-to-back transactions are separated by at least one IDLE cycle.
- **Reset during ACCESS:**
  - The transaction aborts with no `ack`.
  - `mem_we` is suppressed in the reset cycle, so no partial store reaches memory.
- **Simultaneous requests:** `if_req` and `ls_req` high together in IDLE → LOAD/STORE served; fetch must be re-requested.
- **Read path:** memory read is asynchronous, so `mem_rd` is sampled on the same edge that leaves ACCESS.

## Configuration
- `IDMEM_PORT_ALIGN_CHECK_EN` defined: a byte address with bits [1:0] ≠ 0 faults like an out-of-range address.
- Not defined: bits [1:0] are ignored and the access proceeds to the word containing the address.

## Structure
- Package `idmem_pkg` holds:
  - the state encoding (IDLE/ACCESS/DONE);
  - the operation encoding (OP_FETCH/OP_LOAD/OP_STORE);
  - `MEM_WORDS` = 2·2^ADDR_W;
  - the byte-limit constant.
- One sub-module, `idmem_wait_cnt`: loadable down-counter with a zero flag, used for the ACCESS wait states.

## Test plan
- **Fetch:** WAIT_CYCLES=0, memory word 15 = 0x20080005; `if_req`, `if_pc`=0x3C → `ack` at cycle N+2, `ir`=0x20080005, `fault`=0, `mem_we` never high.
- **Store then load:** `ls_req`/`ls_we`=1, addr 0x10, wd 0xDEADBEEF → `mem_we` high exactly one cycle with `mem_addr`=4. Then load 0x10 → `mdr`=0xDEADBEEF.
- **Priority:** `if_req` and `ls_req` both high in IDLE → load served, `ir` unchanged, exactly one `ack`.
- **Out of range:** load at 0x100 → `ack` at N+1 with `fault`=1, `mdr` unchanged, no `mem_we`.
- **Alignment:** with `IDMEM_PORT_ALIGN_CHECK_EN`, load at 0x12 → `fault`=1. Without it → `mdr` = word 4.
- **Wait states and reset:** WAIT_CYCLES=3, store issued and `RST` asserted on the 4th ACCESS cycle → no `mem_we` pulse, no `ack`, all outputs 0 next cycle.

Source files
------------

// File: rtl/idmem_pkg.sv
// Shared encodings and sizing helpers for the idmem_port access controller.
package idmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_e;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned CNT_W      = 4;

  function automatic int unsigned mem_words(input int unsigned addr_w);
    return 32'd2 * (32'd1 << addr_w);
  endfunction

  function automatic int unsigned byte_limit(input int unsigned addr_w);
    return 32'd4 * mem_words(addr_w);
  endfunction

  localparam int unsigned MEM_WORDS  = mem_words(DEF_ADDR_W);
  localparam int unsigned BYTE_LIMIT = byte_limit(DEF_ADDR_W);

endpackage

// File: rtl/idmem_port_wait_cnt.sv
// Loadable down-counter with zero flag; paces the ACCESS wait states.
module idmem_wait_cnt
  import idmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/idmem_port.sv
// Single-port fetch/load/store controller for the 2*2^ADDR_W-word unified memory.
// Optional: define IDMEM_PORT_ALIGN_CHECK_EN to fault on byte addresses with bits [1:0] != 0.
module idmem_port
  import idmem_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_pc,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [DATA_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wd,
  output logic              ack,
  output logic              busy,
  output logic              fault,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam logic [DATA_W-1:0] LIMIT = DATA_W'(byte_limit(ADDR_W));

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wd_q, mem_wd_d;
  logic [DATA_W-1:0] req_addr_s;
  logic              req_bad_s;
  logic              cnt_load_s, cnt_dec_s, cnt_zero_s;

  // Load/store wins arbitration, so its address is the one range-checked.
  assign req_addr_s = ls_req ? ls_addr : if_pc;

`ifdef IDMEM_PORT_ALIGN_CHECK_EN
  assign req_bad_s = (req_addr_s >= LIMIT) | (req_addr_s[1:0] != 2'b00);
`else
  assign req_bad_s = (req_addr_s >= LIMIT);
`endif

  idmem_wait_cnt u_wait_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load_s),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ack_d      = 1'b0;
    fault_d    = fault_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    cnt_load_s = 1'b0;
    cnt_dec_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ls_req || if_req) begin
          if (ls_req) begin
            op_d = ls_we ? OP_STORE : OP_LOAD;
          end else begin
            op_d = OP_FETCH;
          end
          mem_addr_d = DATA_W'(req_addr_s[ADDR_W+2:2]);
          mem_wd_d   = ls_wd;
          cnt_load_s = 1'b1;
          fault_d    = req_bad_s;
          if (req_bad_s) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_zero_s) begin
          case (op_q)
            OP_FETCH: ir_d  = mem_rd;
            OP_LOAD:  mdr_d = mem_rd;
            default:  ir_d  = ir_q;
          endcase
          state_d = S_DONE;
          ack_d   = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      op_q       <= OP_FETCH;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      ir_q       <= {DATA_W{1'b0}};
      mdr_q      <= {DATA_W{1'b0}};
      mem_addr_q <= {DATA_W{1'b0}};
      mem_wd_q   <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
    end
  end

  // Gated by RST so a reset landing on the final ACCESS cycle cannot commit a store.
  assign mem_we = (state_q == S_ACCESS) & cnt_zero_s & (op_q == OP_STORE) & ~RST;

  assign ack      = ack_q;
  assign busy     = busy_q;
  assign fault    = fault_q;
  assign ir       = ir_q;
  assign mdr      = mdr_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;

endmodule

// File: tb/tb_idmem_port.sv
// Scoreboard bench for idmem_port: WAIT_CYCLES=0 instance under random traffic, WAIT_CYCLES=3 instance for latency/reset-abort.
module tb_idmem_port;

`ifdef IDMEM_PORT_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- WAIT_CYCLES = 0 instance ----------------
  logic        rst, if_req, ls_req, ls_we;
  logic [31:0] if_pc, ls_addr, ls_wd;
  logic        ack, busy, fault, mem_we;
  logic [31:0] ir, mdr, mem_addr, mem_wd, mem_rd;
  logic [31:0] env_mem [64];

  assign mem_rd = env_mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_we) env_mem[mem_addr[5:0]] <= mem_wd;

  idmem_port #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(0)) dut (
    .CLK(clk), .RST(rst), .if_req(if_req), .if_pc(if_pc), .ls_req(ls_req), .ls_we(ls_we),
    .ls_addr(ls_addr), .ls_wd(ls_wd), .ack(ack), .busy(busy), .fault(fault), .ir(ir),
    .mdr(mdr), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd));

  // ---------------- WAIT_CYCLES = 3 instance ----------------
  logic        rst3, if_req3, ls_req3, ls_we3;
  logic [31:0] if_pc3, ls_addr3, ls_wd3;
  logic        ack3, busy3, fault3, mem_we3;
  logic [31:0] ir3, mdr3, mem_addr3, mem_wd3, mem_rd3;
  int          we3_n, ack3_n;

  assign mem_rd3 = 32'hA5A5_0003;

  idmem_port #(.ADDR_W(5), .DATA_W(32), .WAIT_CYCLES(3)) dut3 (
    .CLK(clk), .RST(rst3), .if_req(if_req3), .if_pc(if_pc3), .ls_req(ls_req3), .ls_we(ls_we3),
    .ls_addr(ls_addr3), .ls_wd(ls_wd3), .ack(ack3), .busy(busy3), .fault(fault3), .ir(ir3),
    .mdr(mdr3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wd(mem_wd3), .mem_rd(mem_rd3));

  initial forever begin
    @(negedge clk);
    if (mem_we3) we3_n++;
    if (ack3) ack3_n++;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic        flt;
    logic [31:0] ir_v;
    logic [31:0] mdr_v;
    int          we_n;
    logic [31:0] waddr;
    logic [31:0] wd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [64];
  logic [31:0] ref_ir = 32'd0;
  logic [31:0] ref_mdr = 32'd0;

  // Monitor: mem_we pulses are tallied per transaction, everything is judged on ack.
  initial begin : monitor
    exp_t        e;
    int          we_seen;
    logic [31:0] we_addr, we_wd;
    we_seen = 0;
    we_addr = 32'd0;
    we_wd   = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_we) begin
          we_seen++;
          we_addr = mem_addr;
          we_wd   = mem_wd;
        end
        if (ack) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ack", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("fault", {31'd0, fault}, {31'd0, e.flt});
            chk("ir", ir, e.ir_v);
            chk("mdr", mdr, e.mdr_v);
            chk("ack_latency", 32'(cyc - e.acc), 32'(e.lat));
            chk("we_pulses", 32'(we_seen), 32'(e.we_n));
            if (e.we_n != 0) begin
              chk("we_addr", we_addr, e.waddr);
              chk("we_data", we_wd, e.wd);
            end
          end
          we_seen = 0;
        end
      end
    end
  end

  task automatic issue(input bit ifr, input bit lsr, input bit we,
                       input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    logic [31:0] a;
    int          t;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if_req = ifr; ls_req = lsr; ls_we = we; if_pc = pc; ls_addr = addr; ls_wd = wd;
    a = lsr ? addr : pc;
    e.flt   = (a >= 32'd256) || (ALIGN && (a[1:0] != 2'b00));
    e.we_n  = 0;
    e.waddr = 32'd0;
    e.wd    = 32'd0;
    if (!e.flt) begin
      if (!lsr) ref_ir = ref_mem[a[7:2]];
      else if (!we) ref_mdr = ref_mem[a[7:2]];
      else begin
        ref_mem[a[7:2]] = wd;
        e.we_n  = 1;
        e.waddr = a >> 2;
        e.wd    = wd;
      end
    end
    e.ir_v  = ref_ir;
    e.mdr_v = ref_mdr;
    e.lat   = e.flt ? 0 : 1;
    @(posedge clk);
    #1;
    e.acc = cyc;
    sbq.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack && t < 40);
    if (!ack) chk("ack_timeout", 32'd0, 32'd1);
    if_req = 1'b0;
    ls_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] v, a;
    int          k, t, acc;
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_pc = 32'd0; ls_addr = 32'd0; ls_wd = 32'd0;
    rst3 = 1'b1; if_req3 = 1'b0; ls_req3 = 1'b0; ls_we3 = 1'b0;
    if_pc3 = 32'd0; ls_addr3 = 32'd0; ls_wd3 = 32'd0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[15] = 32'h2008_0005;
    ref_mem[15] = 32'h2008_0005;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst3 = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);

    // Directed cases
    issue(1'b1, 1'b0, 1'b0, 32'h3C, 32'h0, 32'h0);
    issue(1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0);
    issue(1'b1, 1'b1, 1'b0, 32'h40, 32'h3C, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h100, 32'h0);
    issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h12, 32'h0);
    issue(1'b1, 1'b0, 1'b0, 32'hFC, 32'h0, 32'h0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0) a = 32'd256 + $urandom_range(0, 100000);
      else if (k == 1) a = $urandom_range(0, 255);
      else a = $urandom_range(0, 63) * 4;
      case ($urandom_range(0, 3))
        0: issue(1'b1, 1'b0, 1'b0, a, $urandom, $urandom);
        1: issue(1'b0, 1'b1, 1'b0, $urandom, a, $urandom);
        2: issue(1'b0, 1'b1, 1'b1, $urandom, a, $urandom);
        default: issue(1'b1, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 63) * 4, a, $urandom);
      endcase
    end
    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(sbq.size()), 32'd0);

    // WAIT_CYCLES=3: load latency
    @(negedge clk);
    ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 32'h20;
    @(posedge clk);
    #1;
    acc = cyc;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!ack3 && t < 40);
    chk("w3_ack_latency", 32'(cyc - acc), 32'd4);
    chk("w3_mdr", mdr3, 32'hA5A5_0003);
    ls_req3 = 1'b0;
    repeat (2) @(negedge clk);

    // WAIT_CYCLES=3: reset on the 4th ACCESS cycle of a store
    we3_n = 0;
    ack3_n = 0;
    ls_req3 = 1'b1; ls_we3 = 1'b1; ls_addr3 = 32'h24; ls_wd3 = 32'h1234_5678;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("w3_busy_in_access", {31'd0, busy3}, 32'd1);
    rst3 = 1'b1;
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    ls_req3 = 1'b0;
    @(negedge clk);
    chk("w3_no_we_pulse", 32'(we3_n), 32'd0);
    chk("w3_no_ack", 32'(ack3_n), 32'd0);
    chk("w3_rst_busy", {31'd0, busy3}, 32'd0);
    chk("w3_rst_fault", {31'd0, fault3}, 32'd0);
    chk("w3_rst_ir", ir3, 32'd0);
    chk("w3_rst_mdr", mdr3, 32'd0);
    chk("w3_rst_mem_addr", mem_addr3, 32'd0);
    chk("w3_rst_mem_wd", mem_wd3, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
